// File: rtl/ram_clr.sv
// Word-addressed RAM with combinational read, clocked write and a
// zeroing sweep that runs after reset and on request.
module ram_clr #(
  parameter int WIDTH          = 16,
  parameter int ADDR_BITS      = 6,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [WIDTH-1:0]     in,
  input  logic                 load,
  input  logic [ADDR_BITS-1:0] address,
  input  logic                 clear,
  output logic [WIDTH-1:0]     out,
  output logic                 busy
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  localparam state_t RST_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ADDR_BITS-1:0] r_cnt;
  logic [ADDR_BITS-1:0] w_cnt_nxt;
  logic [WIDTH-1:0]     r_mem [DEPTH];

  logic                 w_we;
  logic [ADDR_BITS-1:0] w_wa;
  logic [WIDTH-1:0]     w_wd;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= RST_STATE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (clear) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        // cnt wraps to zero on the last word of the sweep
        w_cnt_nxt = r_cnt + 1'b1;
        if (&r_cnt) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign busy = (r_state == CLEAR);

  // No writes while reset is held, so an aborted sweep leaves contents alone
  assign w_we = RST_N & (busy | load);
  assign w_wa = busy ? r_cnt : address;
  assign w_wd = busy ? '0 : in;

  always_ff @(posedge CLK) begin
    if (w_we) r_mem[w_wa] <= w_wd;
  end

  always_comb begin
    out = '0;
    if (!busy) out = r_mem[address];
  end

endmodule

// File: tb/tb_ram_clr.sv
// Scoreboard bench for ram_clr: three parameterisations share one clock,
// expectations are queued by stimulus and checked at the falling edge.
module tb_ram_clr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut0: defaults
  logic        rst0, ld0, cl0, busy0;
  logic [15:0] in0, out0;
  logic [5:0]  a0;
  // dut1: CLEAR_ON_RESET=0, ADDR_BITS=3, WIDTH=8
  logic        rst1, ld1, cl1, busy1;
  logic [7:0]  in1, out1;
  logic [2:0]  a1;
  // dut2: ADDR_BITS=10
  logic        rst2, ld2, cl2, busy2;
  logic [15:0] in2, out2;
  logic [9:0]  a2;

  ram_clr u0 (
    .CLK(clk), .RST_N(rst0), .in(in0), .load(ld0),
    .address(a0), .clear(cl0), .out(out0), .busy(busy0)
  );

  ram_clr #(.WIDTH(8), .ADDR_BITS(3), .CLEAR_ON_RESET(1'b0)) u1 (
    .CLK(clk), .RST_N(rst1), .in(in1), .load(ld1),
    .address(a1), .clear(cl1), .out(out1), .busy(busy1)
  );

  ram_clr #(.ADDR_BITS(10)) u2 (
    .CLK(clk), .RST_N(rst2), .in(in2), .load(ld2),
    .address(a2), .clear(cl2), .out(out2), .busy(busy2)
  );

  typedef struct {
    int          d;
    bit          k;
    logic [15:0] v;
    logic [95:0] nm;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] m0 [64];

  task automatic push(input int d, input bit k,
                      input logic [15:0] v, input logic [95:0] nm);
    exp_t e;
    e.d = d; e.k = k; e.v = v; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [15:0] act;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.d)
        0: act = e.k ? {15'd0, busy0} : out0;
        1: act = e.k ? {15'd0, busy1} : {8'd0, out1};
        default: act = e.k ? {15'd0, busy2} : out2;
      endcase
      n_tests++;
      if (act !== e.v) begin
        n_fail++;
        $display("FAIL %0s dut%0d: got %h want %h",
                 e.nm, e.d, act, e.v);
      end
    end
  end

  task automatic wr0(input logic [5:0] a, input logic [15:0] d);
    step();
    a0 = a; in0 = d; ld0 = 1'b1;
    step();
    ld0 = 1'b0;
    m0[a] = d;
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    ld0 = 0; cl0 = 0; in0 = 0; a0 = 0;
    ld1 = 0; cl1 = 0; in1 = 0; a1 = 0;
    ld2 = 0; cl2 = 0; in2 = 0; a2 = 0;
    foreach (m0[i]) m0[i] = 16'h0000;
    #1;
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    #1;
    push(0, 1, 16'd1, "rst_busy");
    push(0, 0, 16'h0, "rst_out");
    push(1, 1, 16'd0, "rst_busy");
    push(2, 1, 16'd1, "rst_busy");
    step();
    step();
    rst0 = 1'b1;

    // post-reset sweep: busy for edges 1..63, low after edge 64
    for (int j = 1; j <= 64; j++) begin
      step();
      a0 = 6'(j * 7);
      push(0, 1, (j < 64) ? 16'd1 : 16'd0, "sweep_busy");
      if (j < 64) push(0, 0, 16'h0, "sweep_out");
    end
    for (int a = 0; a < 64; a++) begin
      step();
      a0 = 6'(a);
      push(0, 0, 16'h0, "init_rd");
    end

    wr0(6'd0, 16'hBEEF);
    wr0(6'd63, 16'h1234);
    step();
    a0 = 6'd37; in0 = 16'hA5A5; ld0 = 1'b1;
    push(0, 0, 16'h0000, "pre_wr37");
    step();
    ld0 = 1'b0;
    m0[37] = 16'hA5A5;
    push(0, 0, 16'hA5A5, "post_wr37");
    for (int a = 0; a < 64; a++) begin
      step();
      a0 = 6'(a);
      push(0, 0, m0[a], "readback");
    end

    // clear and load together: write happens, then sweep overwrites
    step();
    cl0 = 1'b1; ld0 = 1'b1; in0 = 16'hFFFF; a0 = 6'd5;
    step();
    a0 = 6'd10; in0 = 16'h7777;
    push(0, 1, 16'd1, "clr_busy");
    for (int j = 1; j <= 64; j++) begin
      step();
      if (j == 64) begin
        ld0 = 1'b0; cl0 = 1'b0;
      end
      push(0, 1, (j < 64) ? 16'd1 : 16'd0, "clr_busy");
    end
    foreach (m0[i]) m0[i] = 16'h0000;
    step(); a0 = 6'd5;  push(0, 0, 16'h0, "clr_out5");
    step(); a0 = 6'd10; push(0, 0, 16'h0, "clr_out10");
    step(); a0 = 6'd0;  push(0, 0, 16'h0, "clr_out0");
    step(); a0 = 6'd37; push(0, 0, 16'h0, "clr_out37");

    // reset in the middle of a requested sweep
    wr0(6'd2, 16'h1111);
    step();
    a0 = 6'd2;
    push(0, 0, 16'h1111, "rd_2");
    cl0 = 1'b1;
    step();
    cl0 = 1'b0;
    for (int j = 1; j <= 20; j++) step();
    rst0 = 1'b0;
    push(0, 1, 16'd1, "midrst_busy");
    push(0, 0, 16'h0, "midrst_out");
    step();
    push(0, 1, 16'd1, "midrst_busy");
    rst0 = 1'b1;
    for (int j = 1; j <= 64; j++) begin
      step();
      push(0, 1, (j < 64) ? 16'd1 : 16'd0, "resweep_busy");
    end
    push(0, 0, 16'h0, "resweep_out2");

    // no clear on reset, small geometry
    rst1 = 1'b1;
    step();
    push(1, 1, 16'd0, "noclr_busy");
    a1 = 3'd7; in1 = 8'h5A; ld1 = 1'b1;
    step();
    ld1 = 1'b0;
    push(1, 0, 16'h005A, "wr7");
    rst1 = 1'b0;
    push(1, 1, 16'd0, "rst_busy2");
    push(1, 0, 16'h005A, "keep7_rst");
    step();
    rst1 = 1'b1;
    push(1, 0, 16'h005A, "keep7");
    cl1 = 1'b1;
    step();
    cl1 = 1'b0;
    push(1, 1, 16'd1, "clr8_busy");
    for (int j = 1; j <= 8; j++) begin
      step();
      push(1, 1, (j < 8) ? 16'd1 : 16'd0, "clr8_busy");
    end
    push(1, 0, 16'h0000, "clr8_out7");

    // large geometry: counter wrap at 1023
    rst2 = 1'b1;
    for (int j = 1; j <= 1024; j++) begin
      step();
      push(2, 1, (j < 1024) ? 16'd1 : 16'd0, "big_busy");
    end
    a2 = 10'd1023; in2 = 16'h0001; ld2 = 1'b1;
    push(2, 0, 16'h0000, "big_pre");
    step();
    ld2 = 1'b0;
    push(2, 0, 16'h0001, "big_wr");
    cl2 = 1'b1;
    step();
    cl2 = 1'b0;
    push(2, 1, 16'd1, "big_clr");
    for (int j = 1; j <= 1024; j++) begin
      step();
      push(2, 1, (j < 1024) ? 16'd1 : 16'd0, "big_clr");
    end
    push(2, 0, 16'h0000, "big_out1023");

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
